btb_predictor: RTL and testbench

BTB_PREDICTOR -- requirements
Module: btb_predictor

---
 rtl/bpu_pkg.sv | 37 +++
 rtl/btb_predictor_if.sv | 33 +++
 rtl/bpu_sat_ctr.sv | 20 ++
 rtl/btb_predictor.sv | 91 +++++++++
 tb/tb_btb_predictor.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bpu_pkg.sv
// Shared branch-prediction constants: counter thresholds and
// RISC-V control-flow opcodes used by predictor and decoder.
package bpu_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      CF_NONE,
      CF_BRANCH,
      CF_JAL,
      CF_JALR
   } cf_kind_e;

   // Weakly-taken is the counter midpoint; weakly-not-taken sits just below.
   function automatic int unsigned ctr_wt(input int unsigned bits);
      return 32'd1 << (bits - 1);
   endfunction

   function automatic int unsigned ctr_wnt(input int unsigned bits);
      return ctr_wt(bits) - 1;
   endfunction

   function automatic cf_kind_e cf_kind(input logic [6:0] op);
      cf_kind_e k;
      k = CF_NONE;
      unique case (1'b1)
         (op == OPC_BRANCH): k = CF_BRANCH;
         (op == OPC_JAL):    k = CF_JAL;
         (op == OPC_JALR):   k = CF_JALR;
         default:            k = CF_NONE;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch-lookup and execute-update bundle between the pipeline
// and the branch target buffer.
interface btb_predictor_if #(
   parameter int WIDTH = 32
) ();

   logic             pc_f_i_unused_guard;
   logic [WIDTH-1:0] pc_f_i;
   logic             is_cf_i;
   logic             pred_hit_o;
   logic             pred_taken_o;
   logic [WIDTH-1:0] pred_target_o;
   logic             upd_en_i;
   logic [WIDTH-1:0] upd_pc_i;
   logic [WIDTH-1:0] upd_target_i;
   logic             upd_taken_i;
   logic             upd_pred_i;

   modport master (
      output pc_f_i, is_cf_i,
      output upd_en_i, upd_pc_i, upd_target_i,
      output upd_taken_i, upd_pred_i,
      input  pred_hit_o, pred_taken_o, pred_target_o
   );

   modport slave (
      input  pc_f_i, is_cf_i,
      input  upd_en_i, upd_pc_i, upd_target_i,
      input  upd_taken_i, upd_pred_i,
      output pred_hit_o, pred_taken_o, pred_target_o
   );

endinterface

// File: rtl/bpu_sat_ctr.sv
// Next-value function of a saturating up/down counter.
// Holds at all-ones when counting up and at zero when counting down.
module bpu_sat_ctr #(
   parameter int CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] ctr_i,
   input  logic                inc_i,
   output logic [CTR_BITS-1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (inc_i) begin
         if (ctr_i != '1) ctr_o = ctr_i + CTR_BITS'(1);
      end else begin
         if (ctr_i != '0) ctr_o = ctr_i - CTR_BITS'(1);
      end
   end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating
// counters, combinational lookup and update/mispredict statistics.
module btb_predictor
   import bpu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int ENTRIES   = 16,
   parameter int CTR_BITS  = 2,
   parameter int STAT_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   btb_predictor_if.slave       bus,
   input  logic                 tbl_clr_i,
   output logic [STAT_BITS-1:0] stat_upd_o,
   output logic [STAT_BITS-1:0] stat_mispred_o
);

   localparam int IDXW = $clog2(ENTRIES);
   localparam int TAGW = WIDTH - IDXW - 2;
   localparam logic [CTR_BITS-1:0] WT  = CTR_BITS'(ctr_wt(CTR_BITS));
   localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'(ctr_wnt(CTR_BITS));

   logic [ENTRIES-1:0]  valid_q;
   logic [TAGW-1:0]     tag_q [ENTRIES];
   logic [WIDTH-1:0]    tgt_q [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q [ENTRIES];

   logic [IDXW-1:0]     f_idx;
   logic [TAGW-1:0]     f_tag;
   logic                f_hit;
   logic                f_taken;
   logic [IDXW-1:0]     u_idx;
   logic [TAGW-1:0]     u_tag;
   logic                u_hit;
   logic [CTR_BITS-1:0] ctr_nxt;

   assign f_idx = bus.pc_f_i[IDXW+1:2];
   assign f_tag = bus.pc_f_i[WIDTH-1:IDXW+2];
   assign u_idx = bus.upd_pc_i[IDXW+1:2];
   assign u_tag = bus.upd_pc_i[WIDTH-1:IDXW+2];

   assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign f_taken = bus.is_cf_i && f_hit && ctr_q[f_idx][CTR_BITS-1];

   assign bus.pred_hit_o    = f_hit;
   assign bus.pred_taken_o  = f_taken;
   assign bus.pred_target_o = f_taken ? tgt_q[f_idx]
                                      : bus.pc_f_i + WIDTH'(4);

   bpu_sat_ctr #(
      .CTR_BITS (CTR_BITS)
   ) u_sat_ctr (
      .ctr_i (ctr_q[u_idx]),
      .inc_i (bus.upd_taken_i),
      .ctr_o (ctr_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q        <= '0;
         stat_upd_o     <= '0;
         stat_mispred_o <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
      end else begin
         if (bus.upd_en_i) begin
            if (stat_upd_o != '1)
               stat_upd_o <= stat_upd_o + STAT_BITS'(1);
            if ((bus.upd_pred_i != bus.upd_taken_i) &&
                (stat_mispred_o != '1))
               stat_mispred_o <= stat_mispred_o + STAT_BITS'(1);
         end
         // A fence.i clear discards any same-cycle table write.
         if (tbl_clr_i) begin
            valid_q <= '0;
         end else if (bus.upd_en_i) begin
            if (u_hit) begin
               ctr_q[u_idx] <= ctr_nxt;
               if (bus.upd_taken_i) tgt_q[u_idx] <= bus.upd_target_i;
            end else if (bus.upd_taken_i) begin
               valid_q[u_idx] <= 1'b1;
               tag_q[u_idx]   <= u_tag;
               tgt_q[u_idx]   <= bus.upd_target_i;
               ctr_q[u_idx]   <= WT;
            end
         end
      end
   end

endmodule

// File: tb/tb_btb_predictor.sv
// Scenario bench for btb_predictor: per-cycle lookup expectations
// are queued as stimulus is driven and checked before the next edge.
module tb_btb_predictor;

   logic        clk;
   logic        rst;
   logic        clr;
   logic [15:0] su;
   logic [15:0] sm;
   int          checks;
   int          errors;

   btb_predictor_if #(.WIDTH(32)) bus ();

   btb_predictor #(
      .WIDTH     (32),
      .ENTRIES   (16),
      .CTR_BITS  (2),
      .STAT_BITS (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .tbl_clr_i      (clr),
      .stat_upd_o     (su),
      .stat_mispred_o (sm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [31:0] pc;
      logic        cf;
      logic        ue;
      logic [31:0] upc;
      logic [31:0] utg;
      logic        utk;
      logic        upr;
      logic        cl;
      logic        rs;
      logic        chk;
      logic [33:0] ev;
      logic        st;
      logic [15:0] esu;
      logic [15:0] esm;
   } step_t;

   typedef struct {
      string       nm;
      logic        chk;
      logic [33:0] ev;
      logic        st;
      logic [15:0] esu;
      logic [15:0] esm;
   } exp_t;

   exp_t sb[$];

   function automatic step_t lk(input string nm, input logic [31:0] pc,
                                input logic cf, input logic eh,
                                input logic et, input logic [31:0] etg);
      step_t s;
      s.nm = nm; s.pc = pc; s.cf = cf;
      s.ue = 1'b0; s.upc = '0; s.utg = '0; s.utk = 1'b0; s.upr = 1'b0;
      s.cl = 1'b0; s.rs = 1'b0;
      s.chk = 1'b1; s.ev = {eh, et, etg};
      s.st = 1'b0; s.esu = '0; s.esm = '0;
      return s;
   endfunction

   function automatic step_t up(input step_t s, input logic [31:0] upc,
                                input logic [31:0] utg, input logic utk,
                                input logic upr);
      step_t r;
      r = s;
      r.ue = 1'b1; r.upc = upc; r.utg = utg; r.utk = utk; r.upr = upr;
      return r;
   endfunction

   function automatic step_t cl(input step_t s);
      step_t r;
      r = s;
      r.cl = 1'b1;
      return r;
   endfunction

   // Reset cycles leave the pre-reset lookup unchecked.
   function automatic step_t rs(input step_t s);
      step_t r;
      r = s;
      r.rs = 1'b1;
      r.chk = 1'b0;
      return r;
   endfunction

   function automatic step_t st(input step_t s, input int u, input int m);
      step_t r;
      r = s;
      r.st = 1'b1; r.esu = 16'(u); r.esm = 16'(m);
      return r;
   endfunction

   task automatic apply(input step_t s);
      exp_t e;
      bus.pc_f_i       = s.pc;
      bus.is_cf_i      = s.cf;
      bus.upd_en_i     = s.ue;
      bus.upd_pc_i     = s.upc;
      bus.upd_target_i = s.utg;
      bus.upd_taken_i  = s.utk;
      bus.upd_pred_i   = s.upr;
      clr              = s.cl;
      rst              = s.rs;
      e.nm = s.nm; e.chk = s.chk; e.ev = s.ev;
      e.st = s.st; e.esu = s.esu; e.esm = s.esm;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      step_t q[$];
      exp_t  e;
      q.push_back(rs(cl(up(lk("rst", 32'h100, 1, 0, 0, 0),
                           32'h100, 32'h80, 1, 0))));
      q.push_back(st(lk("post_rst", 32'h100, 1, 0, 0, 32'h104), 0, 0));
      foreach (q[k]) begin
         apply(q[k]);
         @(negedge clk);
         e = sb.pop_front();
         if (e.chk) begin
            checks++;
            if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== e.ev)
               begin
               errors++;
               $display("FAIL %s: got %h exp %h", e.nm,
                  {bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o}, e.ev);
            end
         end
         if (e.st) begin
            checks++;
            if ({su, sm} !== {e.esu, e.esm}) begin
               errors++;
               $display("FAIL %s_stats: got upd=%0d mis=%0d exp upd=%0d mis=%0d",
                  e.nm, su, sm, e.esu, e.esm);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alloc();
      step_t q[$];
      exp_t  e;
      q.push_back(up(lk("alloc_same_cycle", 32'h100, 1, 0, 0, 32'h104),
                     32'h100, 32'h80, 1, 0));
      q.push_back(lk("alloc_next", 32'h100, 1, 1, 1, 32'h80));
      q.push_back(st(lk("alloc_not_cf", 32'h100, 0, 1, 0, 32'h104), 1, 1));
      foreach (q[k]) begin
         apply(q[k]);
         @(negedge clk);
         e = sb.pop_front();
         if (e.chk) begin
            checks++;
            if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== e.ev)
               begin
               errors++;
               $display("FAIL %s: got %h exp %h", e.nm,
                  {bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o}, e.ev);
            end
         end
         if (e.st) begin
            checks++;
            if ({su, sm} !== {e.esu, e.esm}) begin
               errors++;
               $display("FAIL %s_stats: got upd=%0d mis=%0d exp upd=%0d mis=%0d",
                  e.nm, su, sm, e.esu, e.esm);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   // Counter starts at 2; taken updates use upd_pred_i=1 so only the
   // not-taken ones count as mispredictions.
   task automatic test_saturation();
      step_t q[$];
      exp_t  e;
      q.push_back(up(lk("sat_dn0", 32'h100, 1, 1, 1, 32'h80),
                     32'h100, 32'h80, 0, 1));
      q.push_back(up(lk("sat_dn1", 32'h100, 1, 1, 0, 32'h104),
                     32'h100, 32'h80, 0, 1));
      q.push_back(up(lk("sat_dn2", 32'h100, 1, 1, 0, 32'h104),
                     32'h100, 32'h80, 0, 1));
      q.push_back(up(lk("sat_up0", 32'h100, 1, 1, 0, 32'h104),
                     32'h100, 32'h80, 1, 1));
      q.push_back(up(lk("sat_up1", 32'h100, 1, 1, 0, 32'h104),
                     32'h100, 32'h80, 1, 1));
      q.push_back(up(lk("sat_up2", 32'h100, 1, 1, 1, 32'h80),
                     32'h100, 32'h80, 1, 1));
      q.push_back(up(lk("sat_up3", 32'h100, 1, 1, 1, 32'h80),
                     32'h100, 32'h90, 1, 1));
      q.push_back(up(lk("sat_hold", 32'h100, 1, 1, 1, 32'h90),
                     32'h100, 32'h70, 0, 1));
      q.push_back(st(lk("sat_after", 32'h100, 1, 1, 1, 32'h90), 9, 5));
      foreach (q[k]) begin
         apply(q[k]);
         @(negedge clk);
         e = sb.pop_front();
         if (e.chk) begin
            checks++;
            if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== e.ev)
               begin
               errors++;
               $display("FAIL %s: got %h exp %h", e.nm,
                  {bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o}, e.ev);
            end
         end
         if (e.st) begin
            checks++;
            if ({su, sm} !== {e.esu, e.esm}) begin
               errors++;
               $display("FAIL %s_stats: got upd=%0d mis=%0d exp upd=%0d mis=%0d",
                  e.nm, su, sm, e.esu, e.esm);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alias();
      step_t q[$];
      exp_t  e;
      q.push_back(up(lk("alias_miss", 32'h140, 1, 0, 0, 32'h144),
                     32'h140, 32'h200, 1, 1));
      q.push_back(lk("alias_old", 32'h100, 1, 0, 0, 32'h104));
      q.push_back(st(lk("alias_new", 32'h140, 1, 1, 1, 32'h200), 10, 5));
      foreach (q[k]) begin
         apply(q[k]);
         @(negedge clk);
         e = sb.pop_front();
         if (e.chk) begin
            checks++;
            if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== e.ev)
               begin
               errors++;
               $display("FAIL %s: got %h exp %h", e.nm,
                  {bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o}, e.ev);
            end
         end
         if (e.st) begin
            checks++;
            if ({su, sm} !== {e.esu, e.esm}) begin
               errors++;
               $display("FAIL %s_stats: got upd=%0d mis=%0d exp upd=%0d mis=%0d",
                  e.nm, su, sm, e.esu, e.esm);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mispred();
      step_t q[$];
      exp_t  e;
      q.push_back(rs(lk("rst2", 32'h180, 1, 0, 0, 0)));
      q.push_back(up(lk("nalloc0", 32'h180, 1, 0, 0, 32'h184),
                     32'h180, 32'h400, 0, 1));
      q.push_back(up(lk("nalloc1", 32'h180, 1, 0, 0, 32'h184),
                     32'h180, 32'h400, 0, 1));
      q.push_back(st(lk("nalloc_chk", 32'h180, 1, 0, 0, 32'h184), 2, 2));
      foreach (q[k]) begin
         apply(q[k]);
         @(negedge clk);
         e = sb.pop_front();
         if (e.chk) begin
            checks++;
            if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== e.ev)
               begin
               errors++;
               $display("FAIL %s: got %h exp %h", e.nm,
                  {bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o}, e.ev);
            end
         end
         if (e.st) begin
            checks++;
            if ({su, sm} !== {e.esu, e.esm}) begin
               errors++;
               $display("FAIL %s_stats: got upd=%0d mis=%0d exp upd=%0d mis=%0d",
                  e.nm, su, sm, e.esu, e.esm);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_clear();
      step_t q[$];
      exp_t  e;
      q.push_back(up(lk("clr_alloc", 32'h100, 1, 0, 0, 32'h104),
                     32'h100, 32'h80, 1, 1));
      q.push_back(cl(up(lk("clr_upd", 32'h100, 1, 1, 1, 32'h80),
                        32'h100, 32'h300, 1, 0)));
      q.push_back(st(lk("clr_after", 32'h100, 1, 0, 0, 32'h104), 4, 3));
      q.push_back(rs(cl(up(lk("rst_clr", 32'h100, 1, 0, 0, 0),
                           32'h100, 32'h80, 1, 0))));
      q.push_back(st(lk("rst_clr_after", 32'h100, 1, 0, 0, 32'h104), 0, 0));
      foreach (q[k]) begin
         apply(q[k]);
         @(negedge clk);
         e = sb.pop_front();
         if (e.chk) begin
            checks++;
            if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== e.ev)
               begin
               errors++;
               $display("FAIL %s: got %h exp %h", e.nm,
                  {bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o}, e.ev);
            end
         end
         if (e.st) begin
            checks++;
            if ({su, sm} !== {e.esu, e.esm}) begin
               errors++;
               $display("FAIL %s_stats: got upd=%0d mis=%0d exp upd=%0d mis=%0d",
                  e.nm, su, sm, e.esu, e.esm);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   // Each cycle allocates a new entry while looking up last cycle's one.
   task automatic test_back_to_back();
      step_t q[$];
      exp_t  e;
      q.push_back(up(lk("b2b_0", 32'h1000, 1, 0, 0, 32'h1004),
                     32'h1000, 32'h2000, 1, 1));
      for (int i = 1; i < 4; i++)
         q.push_back(up(lk($sformatf("b2b_%0d", i),
                           32'h1000 + 32'(4 * (i - 1)), 1, 1, 1,
                           32'h2000 + 32'(16 * (i - 1))),
                        32'h1000 + 32'(4 * i), 32'h2000 + 32'(16 * i), 1, 1));
      q.push_back(lk("b2b_last", 32'h100C, 1, 1, 1, 32'h2030));
      q.push_back(lk("pc_lsb_ignored", 32'h1002, 1, 1, 1, 32'h2000));
      q.push_back(st(lk("pc_wrap", 32'hFFFF_FFFC, 0, 0, 0, 32'h0), 4, 0));
      foreach (q[k]) begin
         apply(q[k]);
         @(negedge clk);
         e = sb.pop_front();
         if (e.chk) begin
            checks++;
            if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== e.ev)
               begin
               errors++;
               $display("FAIL %s: got %h exp %h", e.nm,
                  {bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o}, e.ev);
            end
         end
         if (e.st) begin
            checks++;
            if ({su, sm} !== {e.esu, e.esm}) begin
               errors++;
               $display("FAIL %s_stats: got upd=%0d mis=%0d exp upd=%0d mis=%0d",
                  e.nm, su, sm, e.esu, e.esm);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_alloc();
      test_saturation();
      test_alias();
      test_mispred();
      test_clear();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
